ps2_key_tx: RTL

PS/2 device-side transmitter. It emulates a keyboard driving keyb_clk/keyb_data toward the calculator's PS/2 receiver. Key events are queued in a small FIFO and serialised as standard 11-bit PS/2 frames. A release event expands into the break sequence F0 followed by the code. The block is used as synthesizable stimulus in system benches and for the FPGA self-test path.

---
 rtl/ps2_key_tx_if.sv | 10 +
 rtl/ps2_key_tx.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/ps2_key_tx_if.sv
// rtl/ps2_key_tx_if.sv - key-event handshake bundle for the PS/2 device transmitter
interface ps2_key_tx_if;
    logic [7:0] key_code;
    logic       key_release;
    logic       key_valid;
    logic       key_ready;

    modport master (output key_code, output key_release, output key_valid, input key_ready);
    modport slave  (input key_code, input key_release, input key_valid, output key_ready);
endinterface

// File: rtl/ps2_key_tx.sv
// rtl/ps2_key_tx.sv - PS/2 keyboard-side frame transmitter with key-event FIFO
module ps2_key_tx #(
    parameter int CLK_HALF   = 5,
    parameter int GAP_CYCLES = 20,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    ps2_key_tx_if.slave       key_if,
    input  logic              host_inhibit,
    output logic              keyb_clk,
    output logic              keyb_data,
    output logic              busy,
    output logic              frame_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(CLK_HALF - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_BIT_HIGH, S_BIT_LOW, S_GAP} state_t;

    state_t          r_state, w_state_next;
    logic [8:0]      r_mem [FIFO_DEPTH];
    logic [AW:0]     r_wr_ptr, r_rd_ptr;
    logic [PW-1:0]   r_phase_cnt;
    logic [3:0]      r_bit_cnt;
    logic [GW-1:0]   r_gap_cnt;
    logic [10:0]     r_shift;
    logic            r_f0_sent;
    logic            r_is_f0;
    logic            r_frame_done;

    logic            w_empty, w_full, w_push, w_pop;
    logic [8:0]      w_head;
    logic [7:0]      w_byte;
    logic            w_sel_f0;
    logic            w_phase_last, w_bit_last, w_gap_last;
    logic            w_frame_end;

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push   = key_if.key_valid & ~w_full;
    assign w_head   = r_mem[r_rd_ptr[AW-1:0]];
    // A release entry sends F0 first; the code goes out once F0 has completed.
    assign w_sel_f0 = w_head[8] & ~r_f0_sent;
    assign w_byte   = w_sel_f0 ? 8'hF0 : w_head[7:0];

    assign w_phase_last = (r_phase_cnt == PH_LAST);
    assign w_bit_last   = (r_bit_cnt == 4'd10);
    assign w_gap_last   = (r_gap_cnt == GAP_LAST);
    // Entry leaves the FIFO only after its final (code) frame completes.
    assign w_pop        = w_frame_end & ~r_is_f0;

    assign key_if.key_ready = ~w_full;
    assign keyb_clk   = (r_state != S_BIT_LOW);
    assign keyb_data  = (r_state == S_BIT_HIGH || r_state == S_BIT_LOW) ? r_shift[0] : 1'b1;
    assign busy       = (r_state != S_IDLE) | ~w_empty;
    assign frame_done = r_frame_done;

    // FIFO storage write; contents need no reset, pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {key_if.key_release, key_if.key_code};
        end
    end

    // FIFO pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // FSM next state; inhibit aborts any in-flight frame into GAP.
    always_comb begin
        w_state_next = r_state;
        w_frame_end  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && !host_inhibit) w_state_next = S_LOAD;
            end
            S_LOAD: begin
                w_state_next = host_inhibit ? S_GAP : S_BIT_HIGH;
            end
            S_BIT_HIGH: begin
                if (host_inhibit)      w_state_next = S_GAP;
                else if (w_phase_last) w_state_next = S_BIT_LOW;
            end
            S_BIT_LOW: begin
                if (host_inhibit) begin
                    w_state_next = S_GAP;
                end else if (w_phase_last) begin
                    if (w_bit_last) begin
                        w_state_next = S_GAP;
                        w_frame_end  = 1'b1;
                    end else begin
                        w_state_next = S_BIT_HIGH;
                    end
                end
            end
            S_GAP: begin
                if (!host_inhibit && w_gap_last) w_state_next = w_empty ? S_IDLE : S_LOAD;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Bit timing counters, shift register and sub-frame bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase_cnt  <= '0;
            r_bit_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_shift      <= '1;
            r_f0_sent    <= 1'b0;
            r_is_f0      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            r_phase_cnt  <= (w_state_next != r_state) ? '0 : r_phase_cnt + 1'b1;
            r_gap_cnt    <= (r_state != S_GAP || host_inhibit) ? '0 : r_gap_cnt + 1'b1;
            if (r_state == S_LOAD) begin
                r_shift   <= {1'b1, ~^w_byte, w_byte, 1'b0};
                r_is_f0   <= w_sel_f0;
                r_bit_cnt <= '0;
            end else if (r_state == S_BIT_LOW && w_state_next == S_BIT_HIGH) begin
                r_shift   <= {1'b1, r_shift[10:1]};
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
            if (w_frame_end) r_f0_sent <= r_is_f0;
        end
    end
endmodule
